cavlc_block_sequencer: RTL and testbench
========================================

Name: cavlc_block_sequencer

Overview:
Parametrised control sequencer for the CAVLC residual decoder. It steps each 4x4/chroma block through three stages: coeff_token decode, level decode and zero/run decode. It muxes the owning stage's shift request onto the barrel shifter. Beyond the single-block controller it adds:
- configurable coeff_token latency
- stage skipping for empty and full blocks
- variable MaxNumCoeff (luma, chroma DC, chroma AC)
- a multi-block run counter
- a stall watchdog with sticky error

Parameters:
SHIFT_W, 5, width of all NumShift buses
TOKEN_STAGES, 1, cycles spent in TOKEN before the coeff_token shift (1..15)
TIMEOUT_W, 8, watchdog counter width; timeout at 2^TIMEOUT_W-1 cycles
NUM_BLK_W, 5, width of block-count/run-length fields

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Enable  in  1  run request from external control
BarrelShifterReady  in  1  barrel shifter holds valid bits
MaxNumCoeff  in  5  block max coefficients (16, 15, 4); stable while Busy
NumBlocks  in  NUM_BLK_W  blocks per run, 0 treated as 2^NUM_BLK_W; stable while Busy
TotalCoeff  in  5  from coeff_token decoder
NumShift_CoeffToken  in  SHIFT_W  coeff_token shift amount
NumShift_Level  in  SHIFT_W  level decoder shift amount
ShiftEn_Level  in  1  level decoder shift request
NumShift_Zero  in  SHIFT_W  zero decoder shift amount
ShiftEn_Zero  in  1  zero decoder shift request
LevelDone  in  1  level decode complete
ZeroDone  in  1  zero decode complete
ShiftEn  out  1  to barrel shifter
NumShift  out  SHIFT_W  to barrel shifter
CoeffTokenEnable  out  1  coeff_token decoder enable
LevelEnable  out  1  level decoder enable
ZeroEnable  out  1  zero decoder enable
BlockDone  out  1  one-cycle pulse per finished block
RunDone  out  1  one-cycle pulse when NumBlocks blocks finished
BlockCount  out  NUM_BLK_W  blocks finished in current run
Busy  out  1  state != IDLE (combinational)
Error  out  1  sticky watchdog error

Behaviour:
Reset (async, asynchronous assert):
- State goes to IDLE.
- All counters are cleared.
- Every registered output (CoeffTokenEnable, LevelEnable, ZeroEnable, BlockDone, RunDone, BlockCount, Error) goes to 0.
- ShiftEn, NumShift and Busy are combinational from IDLE, so they are also 0.
- Reset mid-block aborts the block with no BlockDone.

States and transitions:
- IDLE: Enable & BarrelShifterReady -> TOKEN, tokcnt=0.
- TOKEN: tokcnt++ each cycle. When tokcnt==TOKEN_STAGES-1 -> TOKEN_SHIFT.
- TOKEN_SHIFT:
  - ShiftEn=BarrelShifterReady, NumShift=NumShift_CoeffToken.
  - If !BarrelShifterReady: hold state (stall).
  - Else capture TotalCoeff into tc_q. Then tc_q==0 -> DONE; otherwise -> LEVEL.
- LEVEL: ShiftEn/NumShift = Level inputs. On LevelDone: tc_q>=MaxNumCoeff -> DONE (no zeros to decode); otherwise -> ZERO.
- ZERO: ShiftEn/NumShift = Zero inputs. On ZeroDone -> DONE.
- DONE: one cycle.
  - If BlockCount+1==NumBlocks (mod 2^NUM_BLK_W): RunDone set next cycle, BlockCount cleared, -> IDLE.
  - Else: BlockCount++. Enable & BarrelShifterReady -> TOKEN; otherwise -> IDLE.
- ERROR: ShiftEn=0, Error=1. Enable==0 -> IDLE, which clears Error and BlockCount.
- Illegal encodings -> IDLE.

Watchdog:
- wdcnt clears on entry to LEVEL or ZERO.
- It increments each cycle in LEVEL or ZERO while the stage's Done is low.
- At wdcnt==2^TIMEOUT_W-1 -> ERROR; this has priority over a coincident Done.

Outputs and timing:
- ShiftEn/NumShift are combinational from state. They are 0 outside TOKEN_SHIFT, LEVEL and ZERO.
- Registered enables, one cycle behind state:
  - CoeffTokenEnable <= state==TOKEN
  - LevelEnable <= state==LEVEL
  - ZeroEnable <= state==ZERO
  - BlockDone <= state==DONE
  - RunDone <= DONE & last block
- Enable dropping mid-block does not abort; the block completes and the FSM then returns to IDLE.
- Back-to-back blocks: DONE -> TOKEN with no IDLE bubble.

Test Plan:
1. Defaults, MaxNumCoeff=16, NumBlocks=16; TotalCoeff=5, NumShift_CoeffToken=7, LevelDone 3 cycles after LevelEnable, ZeroDone 2 cycles after ZeroEnable -> states IDLE,TOKEN,TOKEN_SHIFT,LEVEL,ZERO,DONE; ShiftEn=1 with NumShift=7 for exactly one cycle; single BlockDone pulse; BlockCount 0->1; RunDone stays 0.
2. TotalCoeff=0 -> TOKEN_SHIFT goes directly to DONE; LevelEnable/ZeroEnable never rise; BlockDone pulses 3 cycles after leaving IDLE.
3. MaxNumCoeff=4, TotalCoeff=4, then a second block with MaxNumCoeff=15, TotalCoeff=15 -> ZERO never entered, ZeroEnable stays 0 in both blocks.
4. NumBlocks=3, Enable held high, each block TotalCoeff=1 -> three BlockDone pulses with no IDLE between blocks; RunDone coincides with the third BlockDone; BlockCount returns to 0; Busy falls after the run.
5. TIMEOUT_W=4, LevelDone held 0 -> ERROR entered after 15 LEVEL cycles; Error=1 and ShiftEn=0; Error holds while Enable=1; Enable=0 -> IDLE and Error=0.
6. BarrelShifterReady=0 for 4 cycles in TOKEN_SHIFT -> ShiftEn=0 and state held; shift occurs on the cycle Ready returns. Separately, assert Reset in ZERO -> all outputs 0 immediately and no BlockDone.

Source files
------------

// File: rtl/cavlc_block_sequencer.sv
// Block-level control sequencer for the CAVLC residual decoder: walks each block through
// coeff_token, level and zero/run decode and routes the owning stage's shift request.
module cavlc_block_sequencer #(
    parameter int unsigned SHIFT_W      = 5,
    parameter int unsigned TOKEN_STAGES = 1,
    parameter int unsigned TIMEOUT_W    = 8,
    parameter int unsigned NUM_BLK_W    = 5
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 BarrelShifterReady,
    input  logic [4:0]           MaxNumCoeff,
    input  logic [NUM_BLK_W-1:0] NumBlocks,
    input  logic [4:0]           TotalCoeff,
    input  logic [SHIFT_W-1:0]   NumShift_CoeffToken,
    input  logic [SHIFT_W-1:0]   NumShift_Level,
    input  logic                 ShiftEn_Level,
    input  logic [SHIFT_W-1:0]   NumShift_Zero,
    input  logic                 ShiftEn_Zero,
    input  logic                 LevelDone,
    input  logic                 ZeroDone,
    output logic                 ShiftEn,
    output logic [SHIFT_W-1:0]   NumShift,
    output logic                 CoeffTokenEnable,
    output logic                 LevelEnable,
    output logic                 ZeroEnable,
    output logic                 BlockDone,
    output logic                 RunDone,
    output logic [NUM_BLK_W-1:0] BlockCount,
    output logic                 Busy,
    output logic                 Error
);

    typedef enum logic [2:0] {
        StIdle,
        StToken,
        StTokenShift,
        StLevel,
        StZero,
        StDone,
        StError
    } state_e;

    localparam logic [3:0]           TokLast = 4'(TOKEN_STAGES - 1);
    // Last count before expiry, so the transition lands as the counter reaches all-ones.
    localparam logic [TIMEOUT_W-1:0] WdLast  = {{(TIMEOUT_W - 1){1'b1}}, 1'b0};

    state_e               state_q, state_d;
    logic [3:0]           tok_cnt_q, tok_cnt_d;
    logic [4:0]           tc_q, tc_d;
    logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [NUM_BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [NUM_BLK_W-1:0] blk_inc;
    logic                 last_blk;
    logic                 run_done_d;

    // Wraps naturally, so NumBlocks==0 means a full 2^NUM_BLK_W run.
    assign blk_inc  = blk_cnt_q + NUM_BLK_W'(1);
    assign last_blk = (blk_inc == NumBlocks);

    always_comb begin
        state_d    = state_q;
        tok_cnt_d  = tok_cnt_q;
        tc_d       = tc_q;
        wd_cnt_d   = wd_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        run_done_d = 1'b0;
        ShiftEn    = 1'b0;
        NumShift   = '0;
        case (state_q)
            StIdle: begin
                if (Enable && BarrelShifterReady) begin
                    state_d   = StToken;
                    tok_cnt_d = '0;
                end
            end
            StToken: begin
                tok_cnt_d = tok_cnt_q + 4'd1;
                if (tok_cnt_q == TokLast) state_d = StTokenShift;
            end
            StTokenShift: begin
                ShiftEn  = BarrelShifterReady;
                NumShift = NumShift_CoeffToken;
                if (BarrelShifterReady) begin
                    tc_d     = TotalCoeff;
                    wd_cnt_d = '0;
                    state_d  = (TotalCoeff == 5'd0) ? StDone : StLevel;
                end
            end
            StLevel: begin
                ShiftEn  = ShiftEn_Level;
                NumShift = NumShift_Level;
                if (wd_cnt_q == WdLast) begin
                    state_d = StError;
                end else if (LevelDone) begin
                    wd_cnt_d = '0;
                    state_d  = (tc_q >= MaxNumCoeff) ? StDone : StZero;
                end else begin
                    wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
                end
            end
            StZero: begin
                ShiftEn  = ShiftEn_Zero;
                NumShift = NumShift_Zero;
                if (wd_cnt_q == WdLast) begin
                    state_d = StError;
                end else if (ZeroDone) begin
                    state_d = StDone;
                end else begin
                    wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
                end
            end
            StDone: begin
                tok_cnt_d = '0;
                if (last_blk) begin
                    run_done_d = 1'b1;
                    blk_cnt_d  = '0;
                    state_d    = StIdle;
                end else begin
                    blk_cnt_d = blk_inc;
                    state_d   = (Enable && BarrelShifterReady) ? StToken : StIdle;
                end
            end
            StError: begin
                if (!Enable) begin
                    state_d   = StIdle;
                    blk_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign Busy       = (state_q != StIdle);
    assign BlockCount = blk_cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q          <= StIdle;
            tok_cnt_q        <= '0;
            tc_q             <= '0;
            wd_cnt_q         <= '0;
            blk_cnt_q        <= '0;
            CoeffTokenEnable <= 1'b0;
            LevelEnable      <= 1'b0;
            ZeroEnable       <= 1'b0;
            BlockDone        <= 1'b0;
            RunDone          <= 1'b0;
            Error            <= 1'b0;
        end else begin
            state_q          <= state_d;
            tok_cnt_q        <= tok_cnt_d;
            tc_q             <= tc_d;
            wd_cnt_q         <= wd_cnt_d;
            blk_cnt_q        <= blk_cnt_d;
            CoeffTokenEnable <= (state_q == StToken);
            LevelEnable      <= (state_q == StLevel);
            ZeroEnable       <= (state_q == StZero);
            BlockDone        <= (state_q == StDone);
            RunDone          <= run_done_d;
            Error            <= (state_d == StError);
        end
    end

endmodule

// File: tb/tb_cavlc_block_sequencer.sv
// Directed bench for cavlc_block_sequencer: inputs change on the falling edge, outputs are
// checked there too; a small responder returns LevelDone/ZeroDone after fixed delays.
module tb_cavlc_block_sequencer;

    localparam int unsigned SHIFT_W   = 5;
    localparam int unsigned NUM_BLK_W = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 ready;
    logic [4:0]           max_num_coeff;
    logic [NUM_BLK_W-1:0] num_blocks;
    logic [4:0]           total_coeff;
    logic [SHIFT_W-1:0]   ns_token;
    logic [SHIFT_W-1:0]   ns_level;
    logic                 se_level;
    logic [SHIFT_W-1:0]   ns_zero;
    logic                 se_zero;
    logic                 level_done = 1'b0;
    logic                 zero_done  = 1'b0;
    logic                 shift_en;
    logic [SHIFT_W-1:0]   num_shift;
    logic                 token_en;
    logic                 level_en;
    logic                 zero_en;
    logic                 block_done;
    logic                 run_done;
    logic [NUM_BLK_W-1:0] block_count;
    logic                 busy;
    logic                 error;

    cavlc_block_sequencer #(
        .SHIFT_W     (SHIFT_W),
        .TOKEN_STAGES(1),
        .TIMEOUT_W   (4),
        .NUM_BLK_W   (NUM_BLK_W)
    ) dut (
        .Clk                (clk),
        .Reset              (rst),
        .Enable             (enable),
        .BarrelShifterReady (ready),
        .MaxNumCoeff        (max_num_coeff),
        .NumBlocks          (num_blocks),
        .TotalCoeff         (total_coeff),
        .NumShift_CoeffToken(ns_token),
        .NumShift_Level     (ns_level),
        .ShiftEn_Level      (se_level),
        .NumShift_Zero      (ns_zero),
        .ShiftEn_Zero       (se_zero),
        .LevelDone          (level_done),
        .ZeroDone           (zero_done),
        .ShiftEn            (shift_en),
        .NumShift           (num_shift),
        .CoeffTokenEnable   (token_en),
        .LevelEnable        (level_en),
        .ZeroEnable         (zero_en),
        .BlockDone          (block_done),
        .RunDone            (run_done),
        .BlockCount         (block_count),
        .Busy               (busy),
        .Error              (error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Event counters sampled just after each rising edge.
    int bd_cnt = 0, rd_cnt = 0, lvl_cyc = 0, zero_cyc = 0, shift_cyc = 0;
    always @(posedge clk) begin
        #1;
        if (block_done) bd_cnt++;
        if (run_done) rd_cnt++;
        if (level_en) lvl_cyc++;
        if (zero_en) zero_cyc++;
        if (shift_en) shift_cyc++;
    end

    // Done responder; a delay of 0 means the stage never completes.
    int lvl_delay  = 3;
    int zero_delay = 2;
    int lvl_n      = 0;
    int zero_n     = 0;
    always @(negedge clk) begin
        if (level_en && lvl_delay > 0 && !level_done) begin
            lvl_n++;
            level_done = (lvl_n == lvl_delay);
        end else begin
            level_done = 1'b0;
            if (!level_en) lvl_n = 0;
        end
        if (zero_en && zero_delay > 0 && !zero_done) begin
            zero_n++;
            zero_done = (zero_n == zero_delay);
        end else begin
            zero_done = 1'b0;
            if (!zero_en) zero_n = 0;
        end
    end

    task automatic wait_bd(input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (block_done) break;
        end
        chk(tag, block_done, 1);
    endtask

    int bd0, rd0, lvl0, zero0, sh0, gaps, cycles;

    initial begin
        rst = 1'b1; enable = 1'b0; ready = 1'b1;
        max_num_coeff = 5'd16; num_blocks = 5'd16; total_coeff = 5'd5;
        ns_token = 5'd7; ns_level = 5'd3; se_level = 1'b0; ns_zero = 5'd9; se_zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_num_shift", num_shift, 0);
        chk("rst_outs", {token_en, level_en, zero_en, block_done, run_done, error}, 0);
        chk("rst_block_count", block_count, 0);

        // Block with all three stages
        bd0 = bd_cnt; rd0 = rd_cnt; zero0 = zero_cyc; sh0 = shift_cyc;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_token_shift_idle", shift_en, 0);
        @(negedge clk);
        chk("t1_token_shift_en", shift_en, 1);
        chk("t1_token_num_shift", num_shift, 7);
        chk("t1_token_en", token_en, 1);
        @(negedge clk);
        chk("t1_level_noshift", shift_en, 0);
        chk("t1_level_en_lag", level_en, 0);
        @(negedge clk);
        chk("t1_level_en", level_en, 1);
        se_level = 1'b1;
        #1;
        chk("t1_level_mux_en", shift_en, 1);
        chk("t1_level_mux_num", num_shift, 3);
        se_level = 1'b0;
        wait_bd(40, "t1_block_done_seen");
        chk("t1_block_count", block_count, 1);
        chk("t1_run_done", run_done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_bd_pulses", bd_cnt - bd0, 1);
        chk("t1_shift_cycles", shift_cyc - sh0, 1);
        chk("t1_zero_entered", (zero_cyc != zero0), 1);
        @(negedge clk);
        chk("t1_bd_one_cycle", block_done, 0);

        // Empty block skips level and zero
        lvl0 = lvl_cyc; zero0 = zero_cyc;
        total_coeff = 5'd0;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("t2_token_shift", shift_en, 1);
        @(negedge clk);
        chk("t2_bd_not_yet", block_done, 0);
        chk("t2_busy_done", busy, 1);
        @(negedge clk);
        chk("t2_bd", block_done, 1);
        chk("t2_block_count", block_count, 2);
        chk("t2_idle", busy, 0);
        chk("t2_no_level", lvl_cyc - lvl0, 0);
        chk("t2_no_zero", zero_cyc - zero0, 0);

        // Full blocks skip zero decode
        lvl0 = lvl_cyc; zero0 = zero_cyc;
        max_num_coeff = 5'd4; total_coeff = 5'd4; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_bd(40, "t3a_block_done_seen");
        chk("t3a_block_count", block_count, 3);
        chk("t3a_level_entered", (lvl_cyc != lvl0), 1);
        chk("t3a_no_zero", zero_cyc - zero0, 0);
        @(negedge clk);
        max_num_coeff = 5'd15; total_coeff = 5'd15; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_bd(40, "t3b_block_done_seen");
        chk("t3b_block_count", block_count, 4);
        chk("t3b_no_zero", zero_cyc - zero0, 0);

        // Three-block run, back to back
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t4_rst_block_count", block_count, 0);
        @(negedge clk);
        rst = 1'b0;
        bd0 = bd_cnt; rd0 = rd_cnt; gaps = 0;
        num_blocks = 5'd3; max_num_coeff = 5'd16; total_coeff = 5'd1; enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (run_done) break;
            if (!busy) gaps++;
        end
        enable = 1'b0;
        chk("t4_run_done", run_done, 1);
        chk("t4_bd_with_run_done", block_done, 1);
        chk("t4_block_count_wrap", block_count, 0);
        chk("t4_busy_fell", busy, 0);
        chk("t4_no_idle_gaps", gaps, 0);
        chk("t4_bd_pulses", bd_cnt - bd0, 3);
        chk("t4_rd_pulses", rd_cnt - rd0, 1);
        @(negedge clk);
        chk("t4_rd_one_cycle", run_done, 0);

        // Watchdog: LEVEL never completes
        lvl_delay = 0; lvl0 = lvl_cyc; cycles = 0;
        total_coeff = 5'd2; se_level = 1'b1; enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cycles++;
            if (error) break;
        end
        chk("t5_error", error, 1);
        chk("t5_error_latency", cycles, 18);
        chk("t5_level_cycles", lvl_cyc - lvl0, 15);
        chk("t5_shift_off", shift_en, 0);
        chk("t5_busy", busy, 1);
        repeat (3) @(negedge clk);
        chk("t5_error_sticky", error, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("t5_error_cleared", error, 0);
        chk("t5_idle", busy, 0);
        se_level = 1'b0; lvl_delay = 3;

        // Barrel shifter stall in TOKEN_SHIFT
        total_coeff = 5'd3; enable = 1'b1;
        @(negedge clk);
        ready = 1'b0; enable = 1'b0;
        @(negedge clk);
        chk("t6_stall_shift", shift_en, 0);
        chk("t6_stall_busy", busy, 1);
        chk("t6_stall_token_en", token_en, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_stall_hold_shift", shift_en, 0);
            chk("t6_stall_hold_level", level_en, 0);
        end
        ready = 1'b1;
        #1;
        chk("t6_resume_shift", shift_en, 1);
        chk("t6_resume_num", num_shift, 7);
        @(negedge clk);
        chk("t6_level_lag", level_en, 0);
        @(negedge clk);
        chk("t6_level_en", level_en, 1);

        // Reset while in ZERO aborts the block
        zero_delay = 0; cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (zero_en) break;
        end
        chk("t6_zero_reached", zero_en, 1);
        se_zero = 1'b1;
        #1;
        chk("t6_zero_mux_en", shift_en, 1);
        chk("t6_zero_mux_num", num_shift, 9);
        bd0 = bd_cnt;
        rst = 1'b1;
        #1;
        chk("t6_rst_shift", shift_en, 0);
        chk("t6_rst_num", num_shift, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_outs", {token_en, level_en, zero_en, block_done, run_done, error}, 0);
        @(negedge clk);
        rst = 1'b0; se_zero = 1'b0; zero_delay = 2;
        repeat (3) @(negedge clk);
        chk("t6_no_block_done", bd_cnt - bd0, 0);
        chk("t6_idle_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
